pll_reset_sequencer: RTL

Sequences board-level reset for the 25 MHz FPGA design: watches the lock outputs of the two PLLs (65 MHz and 18.432 MHz), debounces the S1 push-button, and drives the active-low reset to the attached Z8S180 board plus an active-high system reset for internal logic. Downstream logic and the Z80 board leave reset only after both clocks are locked and stable for a programmable hold time. Sits in the top level between the PLL instances and every reset consumer, clocked from clk25.

---
 rtl/pll_reset_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pll_reset_sequencer.sv
// Board reset sequencer: waits for both PLL locks, filters them, holds reset for a
// programmable time, and lets a debounced push-button force the board back into reset.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_FILTER     = 16,
  parameter int unsigned HOLD_CYCLES     = 25000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       lock_a,
  input  logic       lock_b,
  input  logic       s1_n,
  output logic       reset_n,
  output logic       sys_reset,
  output logic [2:0] status,
  output logic [7:0] rst_count
);

  localparam int unsigned CNT_MAX = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    HOLD      = 3'd2,
    RUN       = 3'd3,
    BUTTON    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [1:0]        lock_a_q, lock_b_q, s1_q;
  logic              btn_q, btn_d, btn_prev_q;
  logic              reset_n_q, sys_reset_q;
  logic [7:0]        rst_count_q, rst_count_d;
  logic              lock_ok, press, release_ev;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      lock_a_q   <= '0;
      lock_b_q   <= '0;
      s1_q       <= '1;
      btn_q      <= 1'b1;
      btn_prev_q <= 1'b1;
      db_cnt_q   <= '0;
    end else begin
      lock_a_q   <= {lock_a_q[0], lock_a};
      lock_b_q   <= {lock_b_q[0], lock_b};
      s1_q       <= {s1_q[0], s1_n};
      btn_q      <= btn_d;
      btn_prev_q <= btn_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Counter runs only while the synchronized pin differs from the accepted level,
  // so any bounce back to the old level restarts the stability window.
  always_comb begin
    db_cnt_d = db_cnt_q;
    btn_d    = btn_q;
    if (s1_q[1] == btn_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
      btn_d    = s1_q[1];
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign lock_ok    = lock_a_q[1] & lock_b_q[1];
  assign press      = btn_prev_q & ~btn_q;
  assign release_ev = ~btn_prev_q & btn_q;

  // State register; reset_n/sys_reset are registered from the next state so they
  // track state==RUN exactly while still coming straight from flops.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      reset_n_q   <= 1'b0;
      sys_reset_q <= 1'b1;
      rst_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_n_q   <= (state_d == RUN);
      sys_reset_q <= (state_d != RUN);
      rst_count_q <= rst_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (press) begin
          state_d = BUTTON;
        end
      end
      BUTTON: begin
        if (!lock_ok) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (release_ev) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rst_count_d = rst_count_q;
    if ((state_q == RUN) && (state_d != RUN) && (rst_count_q != '1))
      rst_count_d = rst_count_q + 1'b1;
    reset_n   = reset_n_q;
    sys_reset = sys_reset_q;
    status    = state_q;
    rst_count = rst_count_q;
  end

endmodule
